// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int WMASK_W = 4;

  localparam logic [WMASK_W-1:0] MASK_B = 4'b0001;
  localparam logic [WMASK_W-1:0] MASK_H = 4'b0011;
  localparam logic [WMASK_W-1:0] MASK_W = 4'b1111;

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - two-input round-robin grant, one-hot outputs
module arb_rr2 import mem_arb_pkg::*; (
  input  logic req_if,
  input  logic req_d,
  input  logic last_owner,
  input  logic enable,
  output logic gnt_if,
  output logic gnt_d
);

  // On a tie the side that did not win last time gets the grant
  always_comb begin
    gnt_if = enable & req_if & (~req_d | (last_owner == OWN_D));
    gnt_d  = enable & req_d  & (~req_if | (last_owner == OWN_IF));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data memory port arbiter, optional watchdog via MEM_ARB_TIMEOUT_EN
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req_valid,
  input  logic [ADDR_W-1:0]  if_req_addr,
  output logic               if_req_ready,
  output logic               if_rsp_valid,
  output logic [DATA_W-1:0]  if_rsp_data,
  input  logic               d_req_valid,
  input  logic [ADDR_W-1:0]  d_req_addr,
  input  logic               d_req_we,
  input  logic [DATA_W-1:0]  d_req_wdata,
  input  logic [WMASK_W-1:0] d_req_wmask,
  output logic               d_req_ready,
  output logic               d_rsp_valid,
  output logic [DATA_W-1:0]  d_rsp_data,
  output logic               mem_req_valid,
  output logic [ADDR_W-1:0]  mem_req_addr,
  output logic               mem_req_we,
  output logic [DATA_W-1:0]  mem_req_wdata,
  output logic [WMASK_W-1:0] mem_req_wmask,
  input  logic               mem_req_ready,
  input  logic               mem_rsp_valid,
  input  logic [DATA_W-1:0]  mem_rsp_data,
  output logic               busy,
  output logic               err
);

  localparam logic [1:0] IDLE = ARB_IDLE;
  localparam logic [1:0] REQ  = ARB_REQ;
  localparam logic [1:0] RSP  = ARB_RSP;

  logic [1:0]         state;
  logic               owner;
  logic               last_owner;
  logic [ADDR_W-1:0]  cap_addr;
  logic               cap_we;
  logic [DATA_W-1:0]  cap_wdata;
  logic [WMASK_W-1:0] cap_wmask;
  logic               gnt_if;
  logic               gnt_d;
  logic               rsp_done;
  logic               tmo_hit;
  logic [DATA_W-1:0]  rsp_word;

  arb_rr2 u_arb (
    .req_if     (if_req_valid),
    .req_d      (d_req_valid),
    .last_owner (last_owner),
    .enable     (state == IDLE),
    .gnt_if     (gnt_if),
    .gnt_d      (gnt_d)
  );

  // Handshakes and the memory request are decoded straight from state and capture registers
  always_comb begin
    if_req_ready  = gnt_if;
    d_req_ready   = gnt_d;
    mem_req_valid = (state == REQ);
    mem_req_addr  = cap_addr;
    mem_req_we    = cap_we;
    mem_req_wdata = cap_wdata;
    mem_req_wmask = cap_wmask;
    busy          = (state != IDLE);
    rsp_done      = (state == RSP) && mem_rsp_valid;
    rsp_word      = tmo_hit ? '0 : mem_rsp_data;
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;

  // A genuine completion on the limit cycle takes priority over the watchdog
  assign tmo_hit = (state != IDLE) && (tmo_cnt == CNT_W'(TIMEOUT)) && !rsp_done;
  assign err     = err_q;

  // Watchdog counts every in-flight cycle; held at zero while idle so REQ entry starts from zero
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= tmo_hit;
      if (state == IDLE) tmo_cnt <= '0;
      else               tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // Transaction FSM: accept winner, present request, route response to the owner
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= OWN_IF;
      last_owner   <= OWN_D;
      cap_addr     <= '0;
      cap_we       <= 1'b0;
      cap_wdata    <= '0;
      cap_wmask    <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      d_rsp_valid  <= 1'b0;
      d_rsp_data   <= '0;
    end else begin
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_if) begin
            cap_addr   <= if_req_addr;
            cap_we     <= 1'b0;
            cap_wdata  <= '0;
            cap_wmask  <= '0;
            owner      <= OWN_IF;
            last_owner <= OWN_IF;
            state      <= REQ;
          end else if (gnt_d) begin
            cap_addr   <= d_req_addr;
            cap_we     <= d_req_we;
            cap_wdata  <= d_req_wdata;
            cap_wmask  <= d_req_wmask;
            owner      <= OWN_D;
            last_owner <= OWN_D;
            state      <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) state <= RSP;
        end
        RSP: ;
        default: state <= IDLE;
      endcase
      if (rsp_done || tmo_hit) begin
        state <= IDLE;
        if (owner == OWN_IF) begin
          if_rsp_valid <= 1'b1;
          if_rsp_data  <= rsp_word;
        end else begin
          d_rsp_valid <= 1'b1;
          d_rsp_data  <= rsp_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        d_req_valid;
  logic [31:0] d_req_addr;
  logic        d_req_we;
  logic [31:0] d_req_wdata;
  logic [3:0]  d_req_wmask;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        busy;
  logic        err;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
    .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    if_req_valid = 0; if_req_addr = 0;
    d_req_valid = 0; d_req_addr = 0; d_req_we = 0; d_req_wdata = 0; d_req_wmask = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
  endtask

  task automatic do_reset;
    rst = 1; clear_inputs();
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset;
    tests_run++; if (if_req_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_if_req_ready: got %0h expected 0", if_req_ready); end
    tests_run++; if (d_req_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_d_req_ready: got %0h expected 0", d_req_ready); end
    tests_run++; if ({if_rsp_valid, d_rsp_valid} !== 2'b00) begin tests_failed++; $display("FAIL rst_rsp_valid: got %0b expected 00", {if_rsp_valid, d_rsp_valid}); end
    tests_run++; if ({if_rsp_data, d_rsp_data} !== 64'h0) begin tests_failed++; $display("FAIL rst_rsp_data: got %0h expected 0", {if_rsp_data, d_rsp_data}); end
    tests_run++; if ({mem_req_valid, mem_req_we, mem_req_wmask} !== 6'h0) begin tests_failed++; $display("FAIL rst_mem_req_ctl: got %0h expected 0", {mem_req_valid, mem_req_we, mem_req_wmask}); end
    tests_run++; if ({mem_req_addr, mem_req_wdata} !== 64'h0) begin tests_failed++; $display("FAIL rst_mem_req_payload: got %0h expected 0", {mem_req_addr, mem_req_wdata}); end
    tests_run++; if ({busy, err} !== 2'b00) begin tests_failed++; $display("FAIL rst_busy_err: got %0b expected 00", {busy, err}); end
  endtask

  task automatic test_single_fetch;
    if_req_valid = 1; if_req_addr = 32'h0000_0010; #1;
    tests_run++; if ({if_req_ready, d_req_ready} !== 2'b10) begin tests_failed++; $display("FAIL fetch_ready_c0: got %0b expected 10", {if_req_ready, d_req_ready}); end
    tick(); if_req_valid = 0; if_req_addr = 0; mem_req_ready = 1; #1;
    tests_run++; if ({mem_req_valid, busy, mem_req_we, mem_req_wmask} !== 7'b1100000) begin tests_failed++; $display("FAIL fetch_req_c1: got %0b expected 1100000", {mem_req_valid, busy, mem_req_we, mem_req_wmask}); end
    tests_run++; if (mem_req_addr !== 32'h0000_0010) begin tests_failed++; $display("FAIL fetch_addr_c1: got %0h expected 10", mem_req_addr); end
    tick(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h0050_0093; #1;
    tests_run++; if ({mem_req_valid, busy, if_rsp_valid} !== 3'b010) begin tests_failed++; $display("FAIL fetch_rsp_state_c2: got %0b expected 010", {mem_req_valid, busy, if_rsp_valid}); end
    tick(); mem_rsp_valid = 0; mem_rsp_data = 0; #1;
    tests_run++; if ({if_rsp_valid, d_rsp_valid, busy} !== 3'b100) begin tests_failed++; $display("FAIL fetch_pulse_c3: got %0b expected 100", {if_rsp_valid, d_rsp_valid, busy}); end
    tests_run++; if (if_rsp_data !== 32'h0050_0093) begin tests_failed++; $display("FAIL fetch_data_c3: got %0h expected 500093", if_rsp_data); end
    tick();
    tests_run++; if ({if_rsp_valid, d_rsp_valid} !== 2'b00) begin tests_failed++; $display("FAIL fetch_pulse_end_c4: got %0b expected 00", {if_rsp_valid, d_rsp_valid}); end
    tests_run++; if (if_rsp_data !== 32'h0050_0093) begin tests_failed++; $display("FAIL fetch_data_hold_c4: got %0h expected 500093", if_rsp_data); end
  endtask

  task automatic test_rr_data_wins;
    if_req_valid = 1; if_req_addr = 32'h20; d_req_valid = 1; d_req_addr = 32'h104; #1;
    tests_run++; if ({if_req_ready, d_req_ready} !== 2'b01) begin tests_failed++; $display("FAIL rr_data_wins: got %0b expected 01", {if_req_ready, d_req_ready}); end
    tick(); if_req_valid = 0; d_req_valid = 0; mem_req_ready = 1; #1;
    tests_run++; if (mem_req_addr !== 32'h104) begin tests_failed++; $display("FAIL rr_addr: got %0h expected 104", mem_req_addr); end
    tick(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h33;
    tick(); mem_rsp_valid = 0; #1;
    tests_run++; if ({d_rsp_valid, if_rsp_valid} !== 2'b10) begin tests_failed++; $display("FAIL rr_rsp_route: got %0b expected 10", {d_rsp_valid, if_rsp_valid}); end
    tests_run++; if (d_rsp_data !== 32'h33) begin tests_failed++; $display("FAIL rr_rsp_data: got %0h expected 33", d_rsp_data); end
  endtask

  task automatic test_tiebreak_back_to_back;
    do_reset();
    if_req_valid = 1; if_req_addr = 32'h40; d_req_valid = 1; d_req_addr = 32'h100; #1;
    tests_run++; if ({if_req_ready, d_req_ready} !== 2'b10) begin tests_failed++; $display("FAIL tie_first_grant: got %0b expected 10", {if_req_ready, d_req_ready}); end
    tick(); if_req_valid = 0; mem_req_ready = 1; #1;
    tests_run++; if (d_req_ready !== 1'b0) begin tests_failed++; $display("FAIL tie_no_accept_busy: got %0h expected 0", d_req_ready); end
    tests_run++; if (mem_req_addr !== 32'h40) begin tests_failed++; $display("FAIL tie_fetch_addr: got %0h expected 40", mem_req_addr); end
    tick(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h1111_1111;
    tick(); mem_rsp_valid = 0; #1;
    tests_run++; if ({if_rsp_valid, d_req_ready, busy} !== 3'b110) begin tests_failed++; $display("FAIL tie_b2b_accept: got %0b expected 110", {if_rsp_valid, d_req_ready, busy}); end
    tick(); d_req_valid = 0; d_req_addr = 0; mem_req_ready = 1; #1;
    tests_run++; if ({mem_req_valid, mem_req_we} !== 2'b10) begin tests_failed++; $display("FAIL tie_data_req: got %0b expected 10", {mem_req_valid, mem_req_we}); end
    tests_run++; if (mem_req_addr !== 32'h100) begin tests_failed++; $display("FAIL tie_data_addr: got %0h expected 100", mem_req_addr); end
    tick(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h2222_2222;
    tick(); mem_rsp_valid = 0; #1;
    tests_run++; if ({d_rsp_valid, if_rsp_valid} !== 2'b10) begin tests_failed++; $display("FAIL tie_data_rsp: got %0b expected 10", {d_rsp_valid, if_rsp_valid}); end
    tests_run++; if (d_rsp_data !== 32'h2222_2222) begin tests_failed++; $display("FAIL tie_data_val: got %0h expected 22222222", d_rsp_data); end
  endtask

  task automatic test_store;
    d_req_valid = 1; d_req_we = 1; d_req_addr = 32'h203; d_req_wdata = 32'h0000_00AB; d_req_wmask = 4'b0001; #1;
    tests_run++; if (d_req_ready !== 1'b1) begin tests_failed++; $display("FAIL store_accept: got %0h expected 1", d_req_ready); end
    tick(); d_req_valid = 0; d_req_we = 0; d_req_addr = 0; d_req_wdata = 0; d_req_wmask = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) mem_req_ready = 1;
      #1;
      tests_run++; if ({mem_req_valid, mem_req_we, mem_req_wmask, mem_req_addr, mem_req_wdata} !== {1'b1, 1'b1, 4'b0001, 32'h203, 32'hAB})
        begin tests_failed++; $display("FAIL store_hold_%0d: got %0h expected %0h", k, {mem_req_valid, mem_req_we, mem_req_wmask, mem_req_addr, mem_req_wdata}, {1'b1, 1'b1, 4'b0001, 32'h203, 32'hAB}); end
      tick();
    end
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hCAFE; #1;
    tests_run++; if (d_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL store_early_ack: got %0h expected 0", d_rsp_valid); end
    tick(); mem_rsp_valid = 0; #1;
    tests_run++; if ({d_rsp_valid, if_rsp_valid} !== 2'b10) begin tests_failed++; $display("FAIL store_ack: got %0b expected 10", {d_rsp_valid, if_rsp_valid}); end
    tick();
  endtask

  task automatic test_stale_response;
    mem_rsp_valid = 1; mem_rsp_data = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) mem_rsp_valid = 0;
      tick();
      tests_run++; if ({if_rsp_valid, d_rsp_valid, busy, mem_req_valid} !== 4'b0000) begin tests_failed++; $display("FAIL stale_%0d: got %0b expected 0000", k, {if_rsp_valid, d_rsp_valid, busy, mem_req_valid}); end
    end
    tests_run++; if ({if_rsp_data, d_rsp_data} !== {32'h1111_1111, 32'h0000_CAFE}) begin tests_failed++; $display("FAIL stale_data_hold: got %0h expected 111111110000cafe", {if_rsp_data, d_rsp_data}); end
  endtask

  task automatic test_reset_mid;
    if_req_valid = 1; if_req_addr = 32'h80;
    tick(); if_req_valid = 0; mem_req_ready = 1;
    tick(); mem_req_ready = 0; rst = 1; #1;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rmid_busy_rsp: got %0h expected 1", busy); end
    tick(); rst = 0; #1;
    tests_run++; if ({busy, mem_req_valid, if_rsp_valid, d_rsp_valid} !== 4'b0000) begin tests_failed++; $display("FAIL rmid_abort: got %0b expected 0000", {busy, mem_req_valid, if_rsp_valid, d_rsp_valid}); end
    mem_rsp_valid = 1; mem_rsp_data = 32'h5555;
    tick(); mem_rsp_valid = 0; #1;
    tests_run++; if ({if_rsp_valid, d_rsp_valid, if_rsp_data} !== 34'h0) begin tests_failed++; $display("FAIL rmid_late_rsp: got %0h expected 0", {if_rsp_valid, d_rsp_valid, if_rsp_data}); end
    d_req_valid = 1; d_req_addr = 32'h300;
    tick(); d_req_valid = 0; d_req_addr = 0; #1;
    tests_run++; if (mem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL rmid_req_up: got %0h expected 1", mem_req_valid); end
    rst = 1;
    tick(); rst = 0; #1;
    tests_run++; if ({mem_req_valid, busy} !== 2'b00) begin tests_failed++; $display("FAIL rmid_req_drop: got %0b expected 00", {mem_req_valid, busy}); end
  endtask

  task automatic test_timeout;
    d_req_valid = 1; d_req_addr = 32'h400; #1;
    tests_run++; if (d_req_ready !== 1'b1) begin tests_failed++; $display("FAIL tmo_accept: got %0h expected 1", d_req_ready); end
    tick(); d_req_valid = 0; d_req_addr = 0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int k = 1; k <= 9; k++) begin
      tests_run++; if ({err, busy, d_rsp_valid} !== 3'b010) begin tests_failed++; $display("FAIL tmo_wait_c%0d: got %0b expected 010", k, {err, busy, d_rsp_valid}); end
      tick();
    end
    tests_run++; if ({err, d_rsp_valid, if_rsp_valid, busy} !== 4'b1100) begin tests_failed++; $display("FAIL tmo_pulse: got %0b expected 1100", {err, d_rsp_valid, if_rsp_valid, busy}); end
    tests_run++; if (d_rsp_data !== 32'h0) begin tests_failed++; $display("FAIL tmo_data: got %0h expected 0", d_rsp_data); end
    if_req_valid = 1; if_req_addr = 32'h500; #1;
    tests_run++; if (if_req_ready !== 1'b1) begin tests_failed++; $display("FAIL tmo_next_accept: got %0h expected 1", if_req_ready); end
    tick(); if_req_valid = 0; if_req_addr = 0; #1;
    tests_run++; if ({mem_req_valid, err, mem_req_addr} !== {1'b1, 1'b0, 32'h500}) begin tests_failed++; $display("FAIL tmo_next_req: got %0h expected %0h", {mem_req_valid, err, mem_req_addr}, {1'b1, 1'b0, 32'h500}); end
`else
    for (int k = 1; k <= 20; k++) begin
      tests_run++; if ({err, busy, mem_req_valid} !== 3'b011) begin tests_failed++; $display("FAIL notmo_wait_c%0d: got %0b expected 011", k, {err, busy, mem_req_valid}); end
      tick();
    end
`endif
    mem_req_ready = 1;
    tick(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h77;
    tick(); mem_rsp_valid = 0; #1;
`ifdef MEM_ARB_TIMEOUT_EN
    tests_run++; if ({if_rsp_valid, if_rsp_data} !== {1'b1, 32'h77}) begin tests_failed++; $display("FAIL tmo_after_rsp: got %0h expected 100000077", {if_rsp_valid, if_rsp_data}); end
`else
    tests_run++; if ({d_rsp_valid, d_rsp_data, err} !== {1'b1, 32'h77, 1'b0}) begin tests_failed++; $display("FAIL notmo_rsp: got %0h expected 2000000ee", {d_rsp_valid, d_rsp_data, err}); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; clear_inputs();
    tick(); tick();
    test_reset();
    rst = 0;
    test_single_fetch();
    test_rr_data_wins();
    test_tiebreak_back_to_back();
    test_store();
    test_stale_response();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
